// File: rtl/dice_display_scan.sv
// dice_display_scan
// Drives an 8-digit common-anode seven-segment display from the dice game
// outputs. Digits 7..4 carry status text, digits 3..2 the decimal dice sum,
// digit 1 die 1 and digit 0 die 2. The inputs are captured once at the start
// of every frame so one frame never shows two different game states. While
// the captured state is a win or a loss, the whole display blinks.

`timescale 1ns/1ps

module dice_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 24
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Win,
    input  logic       Lose,
    input  logic       Roll,
    input  logic [2:0] DiceOut1,
    input  logic [2:0] DiceOut2,
    output logic [7:0] Anode,
    output logic [6:0] Cathode
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST   = FW'(BLINK_FRAMES - 1);

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R_LO  = 7'b0101111;
    localparam logic [6:0] SEG_O_LO  = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Status words, element [3] lands on digit 7 and element [0] on digit 4
    localparam logic [3:0][6:0] TEXT_PASS = {SEG_P, SEG_A, SEG_S, SEG_S};
    localparam logic [3:0][6:0] TEXT_LOSE = {SEG_L, SEG_O, SEG_S, SEG_E};
    localparam logic [3:0][6:0] TEXT_ROLL = {SEG_R_LO, SEG_O_LO, SEG_L, SEG_L};

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } phase_e;

    typedef struct packed {
        logic       win;
        logic       lose;
        logic       roll;
        logic [2:0] die1;
        logic [2:0] die2;
    } snap_t;

    logic [RW-1:0]   refreshQ, refreshD;
    logic [2:0]      idxQ, idxD;
    logic [FW-1:0]   frameQ, frameD;
    phase_e          phaseQ, phaseD;
    snap_t           snapQ, snapD;
    logic [7:0]      anodeQ, anodeD;
    logic [6:0]      cathodeQ, cathodeD;

    logic            refreshWrap;
    logic            frameStart;
    logic            frameEnd;
    logic            blinkActive;
    logic            outBlank;
    logic            sumValid;
    logic [3:0]      diceSum;
    logic [3:0]      sumOnesVal;
    logic [6:0]      sumTensSeg;
    logic [6:0]      sumOnesSeg;
    logic [3:0][6:0] textSeg;
    logic [6:0]      digitSeg;

    function automatic logic [6:0] segDecimal(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // A die of 0 has not been rolled yet and 7 is an illegal face
    function automatic logic [6:0] segDie(input logic [2:0] value);
        logic [6:0] seg;
        case (value)
            3'd0:    seg = SEG_BLANK;
            3'd7:    seg = SEG_DASH;
            default: seg = segDecimal({1'b0, value});
        endcase
        return seg;
    endfunction

    function automatic logic dieIsFace(input logic [2:0] value);
        return (value != 3'd0) && (value != 3'd7);
    endfunction

    // Refresh counter paces each digit; its wrap advances the digit index
    always_comb begin
        refreshWrap = (refreshQ == REFRESH_LAST);
        frameStart  = (refreshQ == '0) && (idxQ == 3'd0);
        frameEnd    = refreshWrap && (idxQ == 3'd7);
        refreshD    = refreshWrap ? '0 : refreshQ + RW'(1);
        idxD        = refreshWrap ? idxQ + 3'd1 : idxQ;
    end

    // Capture the game state only on the first cycle of a frame
    always_comb begin
        snapD = snapQ;
        if (frameStart) begin
            snapD.win  = Win;
            snapD.lose = Lose;
            snapD.roll = Roll;
            snapD.die1 = DiceOut1;
            snapD.die2 = DiceOut2;
        end
        blinkActive = snapD.win | snapD.lose;
    end

    // Blink phase flips every BLINK_FRAMES frames, parked "on" outside win/lose
    always_comb begin
        frameD = frameQ;
        phaseD = phaseQ;
        if (!blinkActive) begin
            frameD = '0;
            phaseD = PHASE_ON;
        end else if (frameEnd) begin
            if (frameQ == FRAME_LAST) begin
                frameD = '0;
                phaseD = (phaseQ == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frameD = frameQ + FW'(1);
            end
        end
    end

    // Work out the segment pattern for the digit currently being scanned
    always_comb begin
        sumValid   = dieIsFace(snapD.die1) && dieIsFace(snapD.die2);
        diceSum    = {1'b0, snapD.die1} + {1'b0, snapD.die2};
        sumOnesVal = (diceSum >= 4'd10) ? (diceSum - 4'd10) : diceSum;
        sumOnesSeg = segDecimal(sumOnesVal);
        sumTensSeg = (diceSum >= 4'd10) ? SEG_1 : SEG_BLANK;

        // Idle and rolling share one word; the roll bit keeps a slot for an idle message
        if (snapD.win) begin
            textSeg = TEXT_PASS;
        end else if (snapD.lose) begin
            textSeg = TEXT_LOSE;
        end else begin
            textSeg = snapD.roll ? TEXT_ROLL : TEXT_ROLL;
        end

        case (idxQ)
            3'd0:    digitSeg = segDie(snapD.die2);
            3'd1:    digitSeg = segDie(snapD.die1);
            3'd2:    digitSeg = sumValid ? sumOnesSeg : SEG_BLANK;
            3'd3:    digitSeg = sumValid ? sumTensSeg : SEG_BLANK;
            default: digitSeg = textSeg[idxQ[1:0]];
        endcase
    end

    // Select the digit enable and blank the whole display in the off phase
    always_comb begin
        outBlank = blinkActive && (phaseQ == PHASE_OFF);
        anodeD   = outBlank ? 8'hFF : ~(8'h01 << idxQ);
        cathodeD = outBlank ? SEG_BLANK : digitSeg;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!reset) begin
            refreshQ <= '0;
            idxQ     <= 3'd0;
            frameQ   <= '0;
            phaseQ   <= PHASE_ON;
            snapQ    <= '0;
            anodeQ   <= 8'hFF;
            cathodeQ <= SEG_BLANK;
        end else begin
            refreshQ <= refreshD;
            idxQ     <= idxD;
            frameQ   <= frameD;
            phaseQ   <= phaseD;
            snapQ    <= snapD;
            anodeQ   <= anodeD;
            cathodeQ <= cathodeD;
        end
    end

    assign Anode   = anodeQ;
    assign Cathode = cathodeQ;

endmodule

// File: tb/tb_dice_display_scan.sv
// tb_dice_display_scan
// Scoreboard bench for dice_display_scan with a 4-cycle digit period and
// 2-frame blink half-period. The stimulus process drives inputs on falling
// edges and queues the hand-computed Anode/Cathode expected after the next
// rising edge; an independent monitor pops and compares after every rising edge.

`timescale 1ns/1ps

module tb_dice_display_scan;

    localparam int REFRESH_DIV  = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYCLES = 8 * REFRESH_DIV;

    typedef struct {
        logic [7:0] anode;
        logic [6:0] cathode;
        string      name;
    } exp_t;

    logic       CLK;
    logic       reset;
    logic       Win;
    logic       Lose;
    logic       Roll;
    logic [2:0] DiceOut1;
    logic [2:0] DiceOut2;
    logic [7:0] Anode;
    logic [6:0] Cathode;

    exp_t scoreQ[$];
    int   assertCount;
    int   failCount;

    dice_display_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .Win     (Win),
        .Lose    (Lose),
        .Roll    (Roll),
        .DiceOut1(DiceOut1),
        .DiceOut2(DiceOut2),
        .Anode   (Anode),
        .Cathode (Cathode)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic pushExpect(input logic [7:0] anode, input logic [6:0] cathode, input string name);
        exp_t e;
        e.anode   = anode;
        e.cathode = cathode;
        e.name    = name;
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        assertCount++;
        if (Anode !== e.anode || Cathode !== e.cathode) begin
            failCount++;
            $display("[TB] FAIL %s: Anode/Cathode got %h/%h expected %h/%h at %0t",
                     e.name, Anode, Cathode, e.anode, e.cathode, $time);
        end
    endtask

    // Hold reset low for the given number of rising edges, then release it
    task automatic applyReset(input int edges, input string name);
        reset = 1'b0;
        for (int i = 0; i < edges; i++) begin
            pushExpect(8'hFF, 7'h7F, name);
            @(negedge CLK);
        end
        reset = 1'b1;
    endtask

    // Queue the expected scan for 'cycles' edges of a frame starting at its first edge.
    // segs[d] is the pattern of digit d; isOn=0 expects a blanked display.
    // At cycle midAt (if >=0) DiceOut1 is changed to midDie1 inside the frame.
    task automatic applyStimulus(input string name, input logic [7:0][6:0] segs, input bit isOn,
                                 input int cycles, input int midAt, input logic [2:0] midDie1);
        logic [7:0] an;
        int         d;
        for (int j = 0; j < cycles; j++) begin
            if (j == midAt) DiceOut1 = midDie1;
            d  = j / REFRESH_DIV;
            an = 8'h01 << d;
            if (isOn) pushExpect(~an, segs[d], $sformatf("%s d%0d", name, d));
            else      pushExpect(8'hFF, 7'h7F, $sformatf("%s off", name));
            @(negedge CLK);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b0;
        Win         = 1'b0;
        Lose        = 1'b0;
        Roll        = 1'b1;
        DiceOut1    = 3'd0;
        DiceOut2    = 3'd0;
        @(negedge CLK);

        $display("[TB] reset and unrolled dice");
        applyReset(3, "reset");
        applyStimulus("blank dice", {7'h2F, 7'h23, 7'h47, 7'h47, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
                      1'b1, FRAME_CYCLES, -1, 3'd0);

        $display("[TB] lose with illegal die");
        Lose = 1'b1; DiceOut1 = 3'd7; DiceOut2 = 3'd2;
        applyStimulus("lose 7+2", {7'h47, 7'h40, 7'h12, 7'h06, 7'h7F, 7'h7F, 7'h3F, 7'h24},
                      1'b1, FRAME_CYCLES, -1, 3'd0);

        $display("[TB] rolling sums");
        Lose = 1'b0; DiceOut1 = 3'd5; DiceOut2 = 3'd6;
        applyStimulus("sum 5+6", {7'h2F, 7'h23, 7'h47, 7'h47, 7'h79, 7'h79, 7'h12, 7'h02},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        DiceOut1 = 3'd6; DiceOut2 = 3'd6;
        applyStimulus("sum 6+6", {7'h2F, 7'h23, 7'h47, 7'h47, 7'h79, 7'h24, 7'h02, 7'h02},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        DiceOut1 = 3'd4; DiceOut2 = 3'd5;
        applyStimulus("sum 4+5", {7'h2F, 7'h23, 7'h47, 7'h47, 7'h7F, 7'h10, 7'h19, 7'h12},
                      1'b1, FRAME_CYCLES, -1, 3'd0);

        $display("[TB] win blinking");
        Win = 1'b1; DiceOut1 = 3'd3; DiceOut2 = 3'd4;
        applyStimulus("win on1",  {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h78, 7'h30, 7'h19},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("win on2",  {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h78, 7'h30, 7'h19},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("win off1", {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h78, 7'h30, 7'h19},
                      1'b0, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("win off2", {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h78, 7'h30, 7'h19},
                      1'b0, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("win on3",  {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h78, 7'h30, 7'h19},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("win on4",  {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h78, 7'h30, 7'h19},
                      1'b1, FRAME_CYCLES, -1, 3'd0);

        $display("[TB] mid-frame input change");
        Win = 1'b0; DiceOut1 = 3'd2; DiceOut2 = 3'd3;
        applyStimulus("snap old", {7'h2F, 7'h23, 7'h47, 7'h47, 7'h7F, 7'h12, 7'h24, 7'h30},
                      1'b1, FRAME_CYCLES, 3 * REFRESH_DIV, 3'd4);
        applyStimulus("snap new", {7'h2F, 7'h23, 7'h47, 7'h47, 7'h7F, 7'h78, 7'h19, 7'h30},
                      1'b1, FRAME_CYCLES, -1, 3'd0);

        $display("[TB] win priority and reset during blink-off");
        Win = 1'b1; Lose = 1'b1; DiceOut1 = 3'd1; DiceOut2 = 3'd1;
        applyStimulus("prio on1", {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h24, 7'h79, 7'h79},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("prio on2", {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h24, 7'h79, 7'h79},
                      1'b1, FRAME_CYCLES, -1, 3'd0);
        applyStimulus("prio off", {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h24, 7'h79, 7'h79},
                      1'b0, 10, -1, 3'd0);
        applyReset(2, "mid reset");
        applyStimulus("after reset", {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h24, 7'h79, 7'h79},
                      1'b1, FRAME_CYCLES, -1, 3'd0);

        assertCount++;
        if (scoreQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", scoreQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dice_display_scan.md
Name: dice_display_scan

Overview:
- Downstream consumer of the dice game FSM outputs (Win, Lose, Roll, DiceOut1, DiceOut2).
- Time-multiplexes an 8-digit common-anode seven-segment display:
  - digits 7..4: status text;
  - digits 3..2: decimal sum of the dice;
  - digit 1: die 1;
  - digit 0: die 2.
- Inputs are snapshotted once per frame so a frame never tears. On Win or Lose the whole display blinks.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is driven. Must be ≥2.
- BLINK_FRAMES, 24: full 8-digit frames per blink half-period.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising CLK edge resets the block.
- Win  in  1  game won.
- Lose  in  1  game lost.
- Roll  in  1  game still rolling.
- DiceOut1  in  3  die 1 value; 0 means not rolled.
- DiceOut2  in  3  die 2 value; 0 means not rolled.
- Anode  out  8  digit enables, active-low, one-hot-low; bit i drives digit i.
- Cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (reset==0 at an edge):
  - Anode=8'hFF, Cathode=7'h7F.
  - refresh counter=0, digit index=0, frame counter=0, blink phase=on.
  - snapshot (Win, Lose, Roll, DiceOut1, DiceOut2)=0.
- Refresh counter:
  - counts 0..REFRESH_DIV-1, then wraps to 0;
  - on wrap, digit index increments 0..7, then wraps to 0.
- Snapshot:
  - loads all five inputs on every edge where refresh counter==0 and index==0, including the first edge after reset release;
  - input changes at any other time are invisible until the next frame start.
- Output timing:
  - Anode and Cathode are registered and decode the post-edge index and snapshot, so they lag the index by one cycle.
  - Edge E1 is the first edge with reset==1. Digit d is driven during cycles [E1+1+d*REFRESH_DIV, E1+1+(d+1)*REFRESH_DIV).
  - During that window Anode = ~(8'b1 << d).
- Digit content (Cathode), active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - P=0001100, A=0001000, S=0010010, L=1000111, O=1000000, E=0000110, r=0101111, o=0100011.
  - blank=1111111, dash=0111111.
- Digits 7..4:
  - Win=1 → "PASS" (Win has priority if Win and Lose are both 1);
  - else Lose=1 → "LOSE";
  - else "roLL" regardless of Roll.
- Digits 1 and 0 (snapshot die 1 / die 2): value 1..6 shows the numeral; 0 shows blank; 7 shows dash.
- Digits 3..2:
  - if either die is 0 or 7, both digits are blank;
  - otherwise sum = die1+die2, 4-bit unsigned, range 2..12;
  - digit 3 = '1' if sum≥10, else blank; digit 2 = sum mod 10.
- Blink (applies only while snapshot Win|Lose==1):
  - frame counter increments when index wraps 7→0;
  - at BLINK_FRAMES-1 the frame counter returns to 0 and blink phase toggles;
  - while phase=off, Anode=8'hFF and Cathode=7'h7F, but the counters keep running.
- When snapshot Win|Lose==0:
  - frame counter is held at 0 and blink phase is forced on;
  - the next Win/Lose starts with a full "on" half-period.
- Reset mid-frame: takes effect at that edge. All outputs are blank on the next cycle, and scanning restarts at digit 0.
- No combinational path from inputs to outputs.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2, frame=32 cycles):
1. Hold reset=0 for 3 edges, then release; DiceOut1=DiceOut2=0, Roll=1 → during reset Anode=FF, Cathode=7F. From E1+1: Anode steps FE,FD,FB,…,7F, each for 4 cycles. Digits 0–3 show 1111111; digits 7..4 show r,o,L,L (0101111, 0100011, 1000111, 1000111).
2. DiceOut1=5, DiceOut2=6, Roll=1 → digit1=0010010, digit0=0000010, digit3=1111001, digit2=1111001 (sum 11).
3. DiceOut1=3, DiceOut2=4, Win=1 → digits 7..4 = P,A,S,S and digit2=1111000. Display is on for 2 frames (64 cycles), then Anode=FF/Cathode=7F for 64 cycles, repeating.
4. Change DiceOut1 from 2 to 4 at index 3 mid-frame → the old value 2 persists through digit 7. The new value 4 appears on digit 1 only in the next frame.
5. DiceOut1=1, DiceOut2=1, Lose=1 with Win=1 simultaneously → "PASS" shown (Win priority), sum digit2=0100100.
6. Assert reset=0 mid-frame during a blink-off phase → next cycle Anode=FF. After release, digit 0 is driven at E1+1 with blink phase on.
